alu_regfile_mc: RTL and testbench

//  Parametrised register-file + ALU execute block for the single-cycle/multi-cycle CPU datapath.

---
 rtl/alu_regfile_mc_if.sv | 35 +++
 rtl/alu_regfile_mc.sv | 165 ++++++++++++++++
 tb/tb_alu_regfile_mc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_mc_if.sv
// rtl/alu_regfile_mc_if.sv - command/result bundle between CPU control and alu_regfile_mc
// Purpose: groups the start/ready/done handshake, the operation fields and the
//          a0/eq observation outputs into one interface.
// Signals:
//   start, ALUctrl, ALUsrc, ImmOp, rs1, rs2, rd, RegWrite : control -> execute block
//   ready, done, a0, eq                                    : execute block -> control
// Modports: master (control side), slave (execute block side).
interface alu_regfile_mc_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int ALU_CTRL_WIDTH = 3
);
  logic                      start;
  logic                      ready;
  logic                      done;
  logic [ALU_CTRL_WIDTH-1:0] ALUctrl;
  logic                      ALUsrc;
  logic [DATA_WIDTH-1:0]     ImmOp;
  logic [ADDRESS_WIDTH-1:0]  rs1;
  logic [ADDRESS_WIDTH-1:0]  rs2;
  logic [ADDRESS_WIDTH-1:0]  rd;
  logic                      RegWrite;
  logic [DATA_WIDTH-1:0]     a0;
  logic                      eq;

  modport master (
    output start, ALUctrl, ALUsrc, ImmOp, rs1, rs2, rd, RegWrite,
    input  ready, done, a0, eq
  );

  modport slave (
    input  start, ALUctrl, ALUsrc, ImmOp, rs1, rs2, rd, RegWrite,
    output ready, done, a0, eq
  );
endinterface

// File: rtl/alu_regfile_mc.sv
// rtl/alu_regfile_mc.sv - register file plus ALU execute block with iterative multiplier
// Purpose: reads rs1/rs2, picks operand 2 (register or immediate), executes one ALU op
//          and writes rd. Single-cycle ops complete every cycle; MUL runs an iterative
//          shift-add multiplier and holds ready low until its result is written.
// Ports:
//   i_clk : clock, all state on rising edge
//   i_rst : asynchronous active-high reset
//   bus   : alu_regfile_mc_if.slave (start/ready/done handshake, op fields, a0, eq)
module alu_regfile_mc #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int A0_INDEX       = 10,
  parameter int MUL_STEP       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  alu_regfile_mc_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int STEPS = DATA_WIDTH / MUL_STEP;
  localparam int CNTW  = $clog2(STEPS + 1);

  localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR  = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_XOR = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLT = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_SLL = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL = ALU_CTRL_WIDTH'(7);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [DATA_WIDTH-1:0]    r_regs [DEPTH];
  logic [DATA_WIDTH-1:0]    r_mcand;
  logic [DATA_WIDTH-1:0]    r_mplier;
  logic [DATA_WIDTH-1:0]    r_acc;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic                     r_rw;
  logic [CNTW-1:0]          r_cnt;
  logic                     r_done;
  logic                     r_eq;

  logic [DATA_WIDTH-1:0]    w_op1;
  logic [DATA_WIDTH-1:0]    w_op2;
  logic [DATA_WIDTH-1:0]    w_rs2_val;
  logic [DATA_WIDTH-1:0]    w_alu;
  logic [DATA_WIDTH-1:0]    w_partial;
  logic                     w_accept;
  logic                     w_is_mul;
  logic                     w_wr_en;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;

  // reg[0] is never written, but force the read to zero so the x0 rule does not
  // depend on the reset value alone.
  assign w_op1     = (bus.rs1 == '0) ? '0 : r_regs[bus.rs1];
  assign w_rs2_val = (bus.rs2 == '0) ? '0 : r_regs[bus.rs2];
  assign w_op2     = bus.ALUsrc ? bus.ImmOp : w_rs2_val;

  assign w_accept  = bus.start && (r_state == S_IDLE);
  assign w_is_mul  = (bus.ALUctrl == OP_MUL);

  assign bus.ready = (r_state == S_IDLE);
  assign bus.done  = r_done;
  assign bus.eq    = r_eq;
  assign bus.a0    = r_regs[ADDRESS_WIDTH'(A0_INDEX)];

  // Single-cycle ALU; MUL is produced by the iterative path, so it and any
  // unlisted code yield 0 here.
  always_comb begin
    w_alu = '0;
    case (bus.ALUctrl)
      OP_ADD:  w_alu = w_op1 + w_op2;
      OP_SUB:  w_alu = w_op1 - w_op2;
      OP_AND:  w_alu = w_op1 & w_op2;
      OP_OR:   w_alu = w_op1 | w_op2;
      OP_XOR:  w_alu = w_op1 ^ w_op2;
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
      OP_SLL:  w_alu = w_op1 << w_op2[SHW-1:0];
      default: w_alu = '0;
    endcase
  end

  // Partial product for the low MUL_STEP multiplier bits; the multiplicand is
  // pre-shifted each cycle so only the low DATA_WIDTH bits are ever kept.
  assign w_partial = DATA_WIDTH'(r_mcand * DATA_WIDTH'(r_mplier[MUL_STEP-1:0]));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and the single regfile write port: the write comes either from
  // an accepted single-cycle op or from the MUL writeback, never both.
  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_wr_addr = bus.rd;
    w_wr_data = w_alu;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) w_next  = S_MUL;
          else          w_wr_en = bus.RegWrite;
        end
      end
      S_MUL: begin
        if (r_cnt == CNTW'(STEPS - 1)) w_next = S_WB;
      end
      S_WB: begin
        w_next    = S_IDLE;
        w_wr_en   = r_rw;
        w_wr_addr = r_rd;
        w_wr_data = r_acc;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en && (w_wr_addr != '0)) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_rd     <= '0;
      r_rw     <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      r_done <= (w_accept && !w_is_mul) || (r_state == S_WB);
      if (w_accept) begin
        r_eq <= (w_op1 == w_op2);
      end
      if (w_accept && w_is_mul) begin
        r_mcand  <= w_op1;
        r_mplier <= w_op2;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_rd     <= bus.rd;
        r_rw     <= bus.RegWrite;
      end else if (r_state == S_MUL) begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << MUL_STEP;
        r_mplier <= r_mplier >> MUL_STEP;
        r_cnt    <= r_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_regfile_mc.sv
// tb/tb_alu_regfile_mc.sv - scoreboard bench for alu_regfile_mc against an architectural model
module tb_alu_regfile_mc;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = 3;
  localparam int MS    = 1;
  localparam int STEPS = DW / MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_regfile_mc_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALU_CTRL_WIDTH(CW)) bus ();

  alu_regfile_mc #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALU_CTRL_WIDTH(CW),
    .A0_INDEX(10), .MUL_STEP(MS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] a0;
    logic        eq;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_regs [32];
  int          cyc        = 0;
  int          busy_from  = 0;
  int          busy_until = -1;
  int          checks     = 0;
  int          errors     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << b[4:0];
      default: return a * b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; while the block is busy, present junk starts that must be ignored.
  task automatic issue(input logic [2:0] op, input logic src, input logic [31:0] imm,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic rw);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    exp_t        e;
    while (cyc <= busy_until) begin
      bus.start    = ($urandom_range(0, 1) == 1);
      bus.ALUctrl  = 3'($urandom);
      bus.ALUsrc   = 1'($urandom);
      bus.ImmOp    = $urandom;
      bus.rs1      = 5'($urandom);
      bus.rs2      = 5'($urandom);
      bus.rd       = 5'($urandom);
      bus.RegWrite = 1'b1;
      step();
    end
    bus.start    = 1'b1;
    bus.ALUctrl  = op;
    bus.ALUsrc   = src;
    bus.ImmOp    = imm;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.rd       = d;
    bus.RegWrite = rw;
    a = m_regs[s1];
    b = src ? imm : m_regs[s2];
    r = model_alu(op, a, b);
    if (rw && d != 5'd0) m_regs[d] = r;
    e.cyc = cyc + ((op == 3'd7) ? STEPS + 2 : 1);
    e.a0  = m_regs[10];
    e.eq  = (a == b);
    sbq.push_back(e);
    if (op == 3'd7) begin
      busy_from  = cyc + 1;
      busy_until = cyc + STEPS + 1;
    end
    step();
    bus.start = 1'b0;
  endtask

  task automatic probe(input logic [4:0] k);
    issue(3'd0, 1'b0, 32'd0, k, 5'd0, 5'd10, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    sbq.delete();
    busy_from  = 0;
    busy_until = -1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    step();
    step();
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done",  {31'd0, bus.done},  32'd0);
    check("rst_a0",    bus.a0,             32'd0);
    check("rst_eq",    {31'd0, bus.eq},    32'd0);
    rst = 1'b0;
    step();
  endtask

  // Monitor: checks ready every cycle and pops the scoreboard on each done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready", {31'd0, bus.ready},
              (cyc >= busy_from && cyc <= busy_until) ? 32'd0 : 32'd1);
        if (bus.done) begin
          if (sbq.size() == 0) begin
            check("spurious_done", {31'd0, bus.done}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("a0", bus.a0, e.a0);
            check("eq", {31'd0, bus.eq}, {31'd0, e.eq});
          end
        end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          e = sbq.pop_front();
          check("done_missing", {31'd0, bus.done}, 32'd1);
        end
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] imm;
    logic [4:0]  d;
    bus.start = 1'b0; bus.ALUctrl = '0; bus.ALUsrc = 1'b0; bus.ImmOp = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.RegWrite = 1'b0;

    do_reset();
    for (int k = 0; k < 32; k++) probe(5'(k));

    issue(3'd0, 1'b1, 32'd5, 5'd0, 5'd0, 5'd10, 1'b1);
    issue(3'd1, 1'b0, 32'd0, 5'd10, 5'd10, 5'd11, 1'b1);
    probe(5'd11);

    issue(3'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd1, 1'b1);
    issue(3'd0, 1'b1, 32'd1, 5'd0, 5'd0, 5'd2, 1'b1);
    issue(3'd5, 1'b0, 32'd0, 5'd1, 5'd2, 5'd10, 1'b1);
    issue(3'd6, 1'b1, 32'd31, 5'd2, 5'd0, 5'd10, 1'b1);
    issue(3'd0, 1'b1, 32'd7, 5'd0, 5'd0, 5'd0, 1'b1);
    probe(5'd0);

    issue(3'd0, 1'b1, 32'h0001_2345, 5'd0, 5'd0, 5'd5, 1'b1);
    issue(3'd0, 1'b1, 32'h0000_0100, 5'd0, 5'd0, 5'd6, 1'b1);
    issue(3'd7, 1'b0, 32'd0, 5'd5, 5'd6, 5'd10, 1'b1);
    issue(3'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd7, 1'b1);
    issue(3'd7, 1'b0, 32'd0, 5'd7, 5'd7, 5'd10, 1'b1);

    for (int n = 0; n < 250; n++) begin
      op  = 3'($urandom_range(0, 7));
      imm = (op == 3'd6 || $urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      d   = ($urandom_range(0, 1) == 1) ? 5'd10 : 5'($urandom_range(0, 15));
      issue(op, 1'($urandom), imm, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            d, ($urandom_range(0, 9) != 0));
      repeat ($urandom_range(0, 2)) step();
      if (n % 50 == 49) for (int k = 1; k < 16; k++) probe(5'(k));
    end

    issue(3'd7, 1'b0, 32'd0, 5'd5, 5'd6, 5'd10, 1'b1);
    repeat (9) step();
    do_reset();
    repeat (STEPS + 8) step();
    check("post_abort_a0", bus.a0, 32'd0);
    for (int k = 1; k < 16; k++) probe(5'(k));

    for (int t = 0; t < 100 && sbq.size() != 0; t++) step();
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
